// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder slice plus a carry flop, processing
//   WIDTH-bit operands LSB-first, one bit per clock.
//
//   state | meaning
//   IDLE  | waiting for operands; in_ready high
//   RUN   | one sum bit produced per edge, WIDTH edges total
//   DONE  | result presented; held until out_ready
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, cin valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum/cout valid (DONE)
//   out_ready  downstream accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       high while in RUN
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sa, sb, ss;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic s_bit, c_bit;

    assign s_bit = sa[0] ^ sb[0] ^ carry;
    assign c_bit = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The result is copied into dedicated output registers on the final RUN
    // edge, so sum/cout stay at the last result while ss is cleared and
    // refilled by the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            ss     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        ss    <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ss    <= {s_bit, ss[WIDTH-1:1]};
                    carry <= c_bit;
                    if (cnt == LAST) begin
                        sum_q  <= {s_bit, ss[WIDTH-1:1]};
                        cout_q <= c_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: the full unsigned sum of the operands, WIDTH+1 bits wide.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Presents one operand set, waits for acceptance and then for out_valid.
    // lat is the number of clock edges from the accept edge to out_valid.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output logic [W:0] res, output int lat);
        int n = 0;
        @(negedge clk);
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = {cout, sum};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, cout, sum);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] ta[4] = '{8'h35, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] tb[4] = '{8'h4A, 8'h01, 8'h00, 8'h00};
        logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   want[4] = '{9'h07F, 9'h100, 9'h100, 9'h000};
        logic [W:0]   res;
        int           lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], res, lat);
            checks++;
            if (lat != W) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, W);
            end
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got {cout,sum}=%h, want %h", i, res, want[i]);
            end
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL directed_done_flags[%0d]: busy=%b in_ready=%b, want 0 0", i, busy, in_ready);
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || {cout, sum} !== want[i]) begin
                errors++;
                $display("FAIL directed_return_idle[%0d]: in_ready=%b out_valid=%b {cout,sum}=%h, want 1 0 %h",
                         i, in_ready, out_valid, {cout, sum}, want[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W:0] res, held;
        logic [W:0] want_new;
        int         lat;
        int         n;
        out_ready = 1'b0;
        do_op(8'h9C, 8'hA7, 1'b1, res, lat);
        held = ref_add(8'h9C, 8'hA7, 1'b1);
        checks++;
        if (res !== held || lat != W) begin
            errors++;
            $display("FAIL bp_first: got %h after %0d edges, want %h after %0d", res, lat, held, W);
        end
        a = 8'h12; b = 8'h34; cin = 1'b1;
        want_new = ref_add(8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || {cout, sum} !== held) begin
                errors++;
                $display("FAIL bp_stall[%0d]: out_valid=%b in_ready=%b busy=%b {cout,sum}=%h, want 1 0 0 %h",
                         i, out_valid, in_ready, busy, {cout, sum}, held);
            end
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: busy=%b, want 1", busy);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({cout, sum} !== want_new || n != W) begin
            errors++;
            $display("FAIL bp_second: got %h after %0d edges, want %h after %0d", {cout, sum}, n, want_new, W);
        end
        @(negedge clk);
    endtask

    task automatic test_churn;
        logic [W:0] expq[$];
        int         acc_cyc[$];
        logic [W:0] got;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3 * (W + 2) + 2; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (out_valid === 1'b1) begin
                got = {cout, sum};
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL churn_unexpected: result %h with nothing pending", got);
                end else if (got !== expq[0]) begin
                    errors++;
                    $display("FAIL churn_result: got %h, want %h", got, expq[0]);
                    void'(expq.pop_front());
                end else begin
                    void'(expq.pop_front());
                end
            end
            if (in_ready === 1'b1) begin
                expq.push_back(ref_add(a, b, cin));
                acc_cyc.push_back(cyc);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc_cyc.size() < 3) begin
            errors++;
            $display("FAIL churn_accept_count: got %0d accepts, want at least 3", acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                errors++;
                $display("FAIL churn_spacing[%0d]: got %0d edges, want %0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
            end
        end
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_reset_midop;
        bit seen;
        out_ready = 1'b1;
        @(negedge clk);
        a = 8'hC3; b = 8'h5E; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_running: busy=%b, want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, cout, sum, in_ready} !== {1'b0, 1'b0, 1'b0, {W{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL midop_async: busy=%b out_valid=%b cout=%b sum=%h in_ready=%b, want 0 0 0 00 1",
                     busy, out_valid, cout, sum, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midop_stale: out_valid/in_ready left idle after reset, out_valid=%b in_ready=%b",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] xa, xb;
        logic         xc;
        logic [W:0]   res, want;
        int           lat;
        int           stall;
        for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
            want = ref_add(xa, xb, xc);
            out_ready = 1'b0;
            do_op(xa, xb, xc, res, lat);
            checks++;
            if (res !== want || lat != W) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h cin=%b got %h after %0d edges, want %h after %0d",
                         i, xa, xb, xc, res, lat, want, W);
            end
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || {cout, sum} !== want) begin
                    errors++;
                    $display("FAIL random_hold[%0d]: out_valid=%b {cout,sum}=%h, want 1 %h",
                             i, out_valid, {cout, sum}, want);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_churn();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around one full-adder slice plus a carry flop. It processes WIDTH-bit operands LSB-first, one bit per clock.
- Sits directly upstream of consumers of the ripple full-adder datapath. It trades area for latency: one adder slice instead of WIDTH.
- Operands enter through a valid/ready handshake. The result leaves through a valid/ready handshake.

Parameters:
- WIDTH, 8: operand and sum width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in the RUN state

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. rst_n low forces state to IDLE and clears all registers immediately.
- Values while rst_n is low and after release: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a into shift register sa and b into shift register sb.
  - Load the carry flop with cin, clear the sum shift register ss, set bit counter cnt=0, go to RUN.
- RUN, each edge:
  - Compute s_bit = sa[0]^sb[0]^carry and c_bit = (sa[0]&sb[0]) | (carry&(sa[0]^sb[0])).
  - Shift sa and sb right by one.
  - Shift s_bit into ss at the MSB, shifting ss right.
  - carry <= c_bit; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1. sum=ss and cout=carry, both stable.
  - On an edge with out_ready=1, go to IDLE. Otherwise hold indefinitely, with no change to sum or cout.
- Timing and throughput:
  - Acceptance edge is T. The RUN edges are T+1..T+WIDTH. out_valid is high in the cycle after edge T+WIDTH.
  - Minimum spacing between accepted operations is WIDTH+2 edges, with no overlap.
  - in_ready is combinational from state==IDLE only. It is 0 in DONE even when out_ready=1.
- Ignored inputs: in_valid in RUN or DONE has no effect. a, b, cin are sampled only at the accept edge, and later changes to them are ignored.
- Output hold rules: sum and cout keep their last result after leaving DONE until the next result arrives. They are observed only when out_valid=1.
- Counter width: $clog2(WIDTH) bits. No wrap beyond WIDTH-1 occurs.
- Reset during RUN or DONE aborts the operation, emits no result, and leaves the block in IDLE after release.
- Arithmetic: unsigned modulo 2^WIDTH. Overflow is reported only through cout.

Test Plan (WIDTH=8):
- Reset, then a=0x35, b=0x4A, cin=0 with out_ready=1 -> out_valid rises 8 edges after accept; sum=0x7F, cout=0; in_ready returns to 1 the cycle after.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum/cout stay constant. Pulse in_valid during this window with a new operand -> not accepted, in_ready=0. Set out_ready=1 -> IDLE, then the new operand is accepted.
- Input churn: change a, b, cin every cycle during RUN, and hold in_valid=1 throughout -> result equals the operands sampled at the accept edge. The next accept happens exactly WIDTH+2 edges after the previous one.
- Reset mid-op: assert rst_n=0 asynchronously at RUN cycle 4 -> busy, out_valid, sum, cout drop to 0 without a clock edge. After release, in_ready=1 and no stale result appears.
- Random: 1000 operations with random a, b, cin and random out_ready stalls -> {cout,sum} == a+b+cin for every result.
